// File: rtl/seq_multiplier_v2.sv
// Iterative shift-add multiplier with per-operation signed/unsigned mode and optional early exit.
// Operates on magnitudes; the sign is reapplied in a single fix-up cycle.
module seq_multiplier_v2 #(
  parameter int WIDTH      = 32,
  parameter int EARLY_EXIT = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_is_signed,
  input  logic [WIDTH-1:0]   i_multiplier,
  input  logic [WIDTH-1:0]   i_multiplicand,
  output logic [2*WIDTH-1:0] o_product,
  output logic               o_ready,
  output logic               o_done
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  // state  | meaning
  // S_IDLE | waiting for start; ready high
  // S_RUN  | one shift-add step per cycle, count runs down to terminal count 1
  // S_FIX  | apply sign to the accumulator, write product, pulse done
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_mcand;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_product;
  logic             r_neg;
  logic             r_done;

  logic [WIDTH-1:0] w_mplier_mag;
  logic [WIDTH-1:0] w_mcand_mag;
  logic [WIDTH-1:0] w_mplier_shr;
  logic [PW-1:0]    w_acc_sum;
  logic             w_last;

  // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
  assign w_mplier_mag = (i_is_signed && i_multiplier[WIDTH-1])
                        ? (~i_multiplier + WIDTH'(1)) : i_multiplier;
  assign w_mcand_mag  = (i_is_signed && i_multiplicand[WIDTH-1])
                        ? (~i_multiplicand + WIDTH'(1)) : i_multiplicand;
  assign w_mplier_shr = r_mplier >> 1;
  assign w_acc_sum    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_last       = (r_count == CW'(1)) ||
                        ((EARLY_EXIT != 0) && (w_mplier_shr == '0));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)  w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count   <= '0;
      r_mplier  <= '0;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_neg     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mplier <= w_mplier_mag;
            r_mcand  <= {{WIDTH{1'b0}}, w_mcand_mag};
            r_neg    <= i_is_signed & (i_multiplier[WIDTH-1] ^ i_multiplicand[WIDTH-1]);
            r_acc    <= '0;
            r_count  <= CW'(WIDTH);
          end
        end
        S_RUN: begin
          r_acc    <= w_acc_sum;
          r_mplier <= w_mplier_shr;
          r_mcand  <= r_mcand << 1;
          r_count  <= r_count - CW'(1);
        end
        S_FIX: begin
          r_product <= r_neg ? (~r_acc + PW'(1)) : r_acc;
          r_done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_ready   = (r_state == S_IDLE);
  assign o_done    = r_done;
  assign o_product = r_product;

endmodule

// File: tb/tb_seq_multiplier_v2.sv
// Scoreboard bench for seq_multiplier_v2 at WIDTH=8, one instance per EARLY_EXIT setting.
module tb_seq_multiplier_v2;

  typedef struct {
    logic [15:0] p;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st[2];
  logic        sg[2];
  logic [7:0]  mr[2];
  logic [7:0]  md[2];
  logic [15:0] prod[2];
  logic        rdy[2];
  logic        dn[2];

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] last[2];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  seq_multiplier_v2 #(.WIDTH(8), .EARLY_EXIT(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(st[0]), .i_is_signed(sg[0]),
    .i_multiplier(mr[0]), .i_multiplicand(md[0]),
    .o_product(prod[0]), .o_ready(rdy[0]), .o_done(dn[0])
  );

  seq_multiplier_v2 #(.WIDTH(8), .EARLY_EXIT(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(st[1]), .i_is_signed(sg[1]),
    .i_multiplier(mr[1]), .i_multiplicand(md[1]),
    .o_product(prod[1]), .o_ready(rdy[1]), .o_done(dn[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input int d, input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] ep, input int lat);
    int   n = 0;
    exp_t e;
    while (!rdy[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[d]) chk($sformatf("ready_timeout_dut%0d", d), 32'd0, 32'd1);
    st[d] = 1'b1;
    sg[d] = s;
    mr[d] = a;
    md[d] = b;
    e.p = ep;
    e.c = cyc + 1 + lat;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(negedge clk);
    st[d] = 1'b0;
    sg[d] = ~s;
    mr[d] = 8'hA5;
    md[d] = 8'h5A;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_pending", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  task automatic chk_reset_state();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_product_dut%0d", d), {16'h0, prod[d]}, 32'd0);
      chk($sformatf("rst_done_dut%0d", d), {31'h0, dn[d]}, 32'd0);
      chk($sformatf("rst_ready_dut%0d", d), {31'h0, rdy[d]}, 32'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      st[d] = 1'b0; sg[d] = 1'b0; mr[d] = '0; md[d] = '0; last[d] = '0;
    end
    fork
      begin : monitor
        exp_t e;
        bit   got;
        forever begin
          @(negedge clk);
          if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
              if (dn[d]) begin
                got = 1'b0;
                if (d == 0 && q0.size() != 0) begin e = q0.pop_front(); got = 1'b1; end
                else if (d == 1 && q1.size() != 0) begin e = q1.pop_front(); got = 1'b1; end
                if (!got) chk($sformatf("unexpected_done_dut%0d", d), 32'd1, 32'd0);
                else begin
                  chk($sformatf("product_dut%0d", d), {16'h0, prod[d]}, {16'h0, e.p});
                  chk($sformatf("done_cycle_dut%0d", d), 32'(cyc), 32'(e.c));
                  last[d] = e.p;
                end
              end else begin
                chk($sformatf("hold_dut%0d", d), {16'h0, prod[d]}, {16'h0, last[d]});
              end
            end
          end
        end
      end
      begin : stimulus
        repeat (2) @(negedge clk);
        chk_reset_state();
        #2 rst_n = 1'b1;
        @(negedge clk);

        issue(0, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 9);
        issue(1, 1'b0, 8'h00, 8'h55, 16'h0000, 2);
        issue(1, 1'b0, 8'h01, 8'h7F, 16'h007F, 2);
        issue(1, 1'b0, 8'h80, 8'h03, 16'h0180, 9);
        issue(0, 1'b1, 8'h80, 8'h80, 16'h4000, 9);
        issue(1, 1'b1, 8'hFD, 8'h05, 16'hFFF1, 3);
        issue(1, 1'b1, 8'h80, 8'h02, 16'hFF00, 9);
        issue(0, 1'b1, 8'hFD, 8'h05, 16'hFFF1, 9);
        issue(1, 1'b0, 8'h05, 8'h06, 16'h001E, 4);
        issue(0, 1'b0, 8'hFD, 8'h05, 16'h04F1, 9);
        issue(0, 1'b1, 8'h00, 8'hFF, 16'h0000, 9);
        issue(0, 1'b1, 8'h7F, 8'h80, 16'hC080, 9);
        issue(0, 1'b0, 8'h02, 8'h02, 16'h0004, 9);
        issue(0, 1'b0, 8'h03, 8'h04, 16'h000C, 9);
        drain();

        // start while busy must be ignored
        issue(0, 1'b0, 8'h0C, 8'h0D, 16'h009C, 9);
        repeat (2) @(negedge clk);
        st[0] = 1'b1; sg[0] = 1'b1; mr[0] = 8'hFF; md[0] = 8'hFF;
        @(negedge clk);
        st[0] = 1'b0;
        drain();

        // asynchronous reset between edges, mid-operation
        issue(0, 1'b0, 8'd200, 8'd100, 16'h4E20, 9);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        q0.delete();
        q1.delete();
        last[0] = '0;
        last[1] = '0;
        #1 chk_reset_state();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        issue(0, 1'b0, 8'd6, 8'd7, 16'd42, 9);
        issue(1, 1'b0, 8'd6, 8'd7, 16'd42, 4);
        drain();
      end
    join_any
    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
